// File: rtl/spi_host.sv
// Mode-0, MSB-first SPI initiator with a word-level valid/ready front end.
// CS may be held low across consecutive words until a word tagged tx_last completes.
module spi_host #(
    parameter int WORD_BITS = 64,
    parameter int CLK_DIV   = 4
) (
    input  logic                 CLK,
    input  logic                 resetn_in,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    input  logic                 tx_last,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int EW = $clog2(2 * WORD_BITS + 1);
    localparam logic [HW-1:0] HALF_MAX  = HW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD_CS,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          half_q, half_d;
    logic [EW-1:0]          edge_q, edge_d;
    logic [WORD_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [WORD_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [WORD_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   sck_q, sck_d;
    logic                   cs_q, cs_d;
    logic                   copi_q, copi_d;
    logic                   last_q, last_d;
    logic                   live_q, live_d;
    logic                   accept;
    logic                   half_wrap;

    // live_q keeps tx_ready low while reset is held, even though state is IDLE.
    assign tx_ready  = live_q && ((state_q == S_IDLE) || (state_q == S_HOLD_CS));
    assign accept    = tx_valid && tx_ready;
    assign half_wrap = (half_q == HALF_MAX);

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != S_IDLE);
    assign SCK      = sck_q;
    assign CS       = cs_q;
    assign COPI     = copi_q;

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        cs_d       = cs_q;
        copi_d     = copi_q;
        last_d     = last_q;
        live_d     = 1'b1;

        case (state_q)
            S_IDLE, S_HOLD_CS: begin
                if (accept) begin
                    tx_sh_d = tx_data;
                    last_d  = tx_last;
                    cs_d    = 1'b0;
                    copi_d  = tx_data[WORD_BITS-1];
                    sck_d   = 1'b0;
                    half_d  = '0;
                    edge_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (half_wrap) begin
                    half_d = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 1'b1;
                    if (!sck_q) begin
                        rx_sh_d = {rx_sh_q[WORD_BITS-2:0], CIPO};
                    end else if (edge_q == EDGE_LAST) begin
                        // Final falling edge: the last rise already captured bit 0.
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = last_q ? S_TRAIL : S_HOLD_CS;
                    end else begin
                        tx_sh_d = tx_sh_q << 1;
                        copi_d  = tx_sh_q[WORD_BITS-2];
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_TRAIL: begin
                if (half_wrap) begin
                    half_d  = '0;
                    cs_d    = 1'b1;
                    copi_d  = 1'b0;
                    state_d = S_GAP;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            S_GAP: begin
                if (half_wrap) begin
                    half_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                copi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q    <= S_IDLE;
            half_q     <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            copi_q     <= 1'b0;
            last_q     <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            copi_q     <= copi_d;
            last_q     <= last_d;
            live_q     <= live_d;
        end
    end

endmodule

// File: tb/tb_spi_host.sv
// Scoreboarded bench for spi_host: an 8-bit/div-2 instance with a responder model,
// plus a default-parameter instance in CIPO=COPI loopback.
module tb_spi_host;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic resetn;

    logic [7:0]  a_tx_data;
    logic        a_tx_valid, a_tx_last, a_tx_ready;
    logic [7:0]  a_rx_data;
    logic        a_rx_valid, a_busy, a_sck, a_cs, a_copi, a_cipo;

    logic [63:0] b_tx_data;
    logic        b_tx_valid, b_tx_last, b_tx_ready;
    logic [63:0] b_rx_data;
    logic        b_rx_valid, b_busy, b_sck, b_cs, b_copi, b_cipo;

    spi_host #(.WORD_BITS(8), .CLK_DIV(2)) dut_a (
        .CLK(CLK), .resetn_in(resetn),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_last(a_tx_last), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy),
        .SCK(a_sck), .CS(a_cs), .COPI(a_copi), .CIPO(a_cipo)
    );

    spi_host dut_b (
        .CLK(CLK), .resetn_in(resetn),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_last(b_tx_last), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy),
        .SCK(b_sck), .CS(b_cs), .COPI(b_copi), .CIPO(b_cipo)
    );

    assign b_cipo = b_copi;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int edge0 = 0;
    int cs_rises = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] resp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor + responder: pops the scoreboard on rx_valid and on every completed COPI word.
    int         bitcnt = 0;
    logic [7:0] cap = '0;
    logic       sck_prev = 1'b0;
    logic       cs_prev = 1'b1;
    logic [7:0] mon_w;
    initial a_cipo = 1'b0;

    always @(negedge CLK) begin
        if (!resetn) begin
            bitcnt   = 0;
            cap      = '0;
            sck_prev = 1'b0;
            cs_prev  = 1'b1;
        end else begin
            if (a_rx_valid) begin
                total++;
                if (exp_rx_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected got=%0h exp=none t=%0t", a_rx_data, $time);
                end else begin
                    mon_w = exp_rx_q.pop_front();
                    if (a_rx_data !== mon_w) begin
                        bad++;
                        $display("FAIL rx_data got=%0h exp=%0h t=%0t", a_rx_data, mon_w, $time);
                    end
                end
            end
            if (a_sck && !sck_prev) begin
                total++;
                if (a_cs !== 1'b0) begin
                    bad++;
                    $display("FAIL sck_rise_cs got=%0b exp=0 t=%0t", a_cs, $time);
                end
                cap = {cap[6:0], a_copi};
                bitcnt++;
                if (bitcnt == 8) begin
                    bitcnt = 0;
                    if (resp_q.size() > 0) void'(resp_q.pop_front());
                    total++;
                    if (exp_tx_q.size() == 0) begin
                        bad++;
                        $display("FAIL copi_unexpected got=%0h exp=none t=%0t", cap, $time);
                    end else begin
                        mon_w = exp_tx_q.pop_front();
                        if (cap !== mon_w) begin
                            bad++;
                            $display("FAIL copi_word got=%0h exp=%0h t=%0t", cap, mon_w, $time);
                        end
                    end
                end
            end
            if (a_cs && !cs_prev) cs_rises++;
            sck_prev = a_sck;
            cs_prev  = a_cs;
        end
        if (resp_q.size() > 0) begin
            mon_w  = resp_q[0];
            a_cipo = mon_w[7-bitcnt];
        end else begin
            a_cipo = 1'b0;
        end
    end

    task automatic send_a(input logic [7:0] d, input logic last, input logic [7:0] resp);
        int n = 0;
        @(negedge CLK);
        while (!a_tx_ready && n < 300) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (!a_tx_ready) begin
            bad++;
            $display("FAIL send_ready got=0 exp=1 t=%0t", $time);
        end else begin
            a_tx_data  = d;
            a_tx_last  = last;
            a_tx_valid = 1'b1;
            exp_tx_q.push_back(d);
            exp_rx_q.push_back(resp);
            resp_q.push_back(resp);
            edge0 = cyc + 1;
            @(negedge CLK);
            a_tx_valid = 1'b0;
            a_tx_data  = 8'($urandom);
            a_tx_last  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_edge(input int k);
        while (cyc < edge0 + k) @(negedge CLK);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (a_busy && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_reached", a_busy, 1'b0);
        repeat (2) @(negedge CLK);
    endtask

    int e_first;
    int rises_before;
    int n;

    initial begin
        resetn     = 1'b1;
        a_tx_data  = '0; a_tx_valid = 1'b0; a_tx_last = 1'b0;
        b_tx_data  = '0; b_tx_valid = 1'b0; b_tx_last = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_tx_ready", a_tx_ready, 1'b0);
        chk("rst_cs", a_cs, 1'b1);
        chk("rst_sck", a_sck, 1'b0);
        resetn = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_sck", a_sck, 1'b0);
            chk("idle_cs", a_cs, 1'b1);
            chk("idle_copi", a_copi, 1'b0);
            chk("idle_ready", a_tx_ready, 1'b1);
            chk("idle_busy", a_busy, 1'b0);
            chk("idle_rxv", a_rx_valid, 1'b0);
        end

        // Single word 0xA5, responder returns 0x3C, edge-accurate timing
        send_a(8'hA5, 1'b1, 8'h3C);
        chk("e0_cs", a_cs, 1'b0);
        chk("e0_copi", a_copi, 1'b1);
        chk("e0_sck", a_sck, 1'b0);
        wait_edge(1);  chk("e1_sck", a_sck, 1'b0);
        wait_edge(2);  chk("e2_sck", a_sck, 1'b1);
        wait_edge(31); chk("e31_sck", a_sck, 1'b1);
        wait_edge(32); chk("e32_sck", a_sck, 1'b0);
        chk("e32_rxv", a_rx_valid, 1'b1);
        chk("e32_cs", a_cs, 1'b0);
        wait_edge(33); chk("e33_rxv", a_rx_valid, 1'b0);
        chk("e33_cs", a_cs, 1'b0);
        wait_edge(34); chk("e34_cs", a_cs, 1'b1);
        chk("e34_ready", a_tx_ready, 1'b0);
        wait_edge(35); chk("e35_ready", a_tx_ready, 1'b0);
        wait_edge(36); chk("e36_ready", a_tx_ready, 1'b1);
        chk("e36_busy", a_busy, 1'b0);
        wait_idle();

        // Back-to-back words share one CS window
        rises_before = cs_rises;
        send_a(8'h01, 1'b0, 8'h9E);
        e_first = edge0;
        send_a(8'hFF, 1'b1, 8'h42);
        chk("b2b_accept_edge", 32'(edge0 - e_first), 32'd33);
        wait_idle();
        chk("b2b_cs_rises", 32'(cs_rises - rises_before), 32'd1);

        // tx_valid during SHIFT is ignored; tx_data churn does not leak onto COPI
        send_a(8'hC3, 1'b1, 8'h5A);
        wait_edge(10);
        chk("midshift_ready", a_tx_ready, 1'b0);
        a_tx_valid = 1'b1;
        a_tx_data  = 8'h55;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            a_tx_data = 8'($urandom);
        end
        a_tx_valid = 1'b0;
        wait_idle();

        // Reset mid-word
        send_a(8'h5A, 1'b1, 8'hE7);
        wait_edge(10);
        resetn = 1'b0;
        #1;
        chk("arst_cs", a_cs, 1'b1);
        chk("arst_sck", a_sck, 1'b0);
        chk("arst_copi", a_copi, 1'b0);
        chk("arst_busy", a_busy, 1'b0);
        exp_rx_q.delete();
        exp_tx_q.delete();
        resp_q.delete();
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        send_a(8'h81, 1'b1, 8'h7B);
        wait_idle();

        // Randomized words, random tx_last and gaps
        for (int i = 0; i < 20; i++) begin
            send_a(8'($urandom), (i == 19) ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        wait_idle();
        chk("sb_rx_empty", 32'(exp_rx_q.size()), 32'd0);
        chk("sb_tx_empty", 32'(exp_tx_q.size()), 32'd0);

        // Default-parameter loopback
        @(negedge CLK);
        chk("b_ready", b_tx_ready, 1'b1);
        b_tx_data  = 64'h0123456789ABCDEF;
        b_tx_last  = 1'b1;
        b_tx_valid = 1'b1;
        e_first    = cyc + 1;
        @(negedge CLK);
        b_tx_valid = 1'b0;
        b_tx_data  = 64'hFFFF_0000_FFFF_0000;
        n = 0;
        while (!b_rx_valid && n < 700) begin
            @(negedge CLK);
            n++;
        end
        chk("b_rx_valid", b_rx_valid, 1'b1);
        chk("b_rx_edge", 32'(cyc - e_first), 32'd512);
        chk("b_rx_data", b_rx_data, 64'h0123456789ABCDEF);
        repeat (12) @(negedge CLK);
        chk("b_cs_idle", b_cs, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_host.md
# spi_host

SPI initiator (mode 0, MSB first) that drives the rapcore SPI responder pins (SCK, CS, COPI, CIPO) from a simple word-level valid/ready interface. It sits in the user area between a host-side command source (Wishbone bridge or test sequencer) and the motor-control core. It lets firmware issue full-duplex 64-bit register transactions without bit-banging GPIO. CS can be held low across multi-word transactions.

## Interface
Parameters:
- WORD_BITS, 64, bits per SPI word; legal range 2..64.
- CLK_DIV, 4, CLK cycles per SCK half-period; legal minimum is 1.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- resetn_in  in  1  asynchronous, active-low reset.
- tx_data  in  WORD_BITS  word to transmit; sampled only on the acceptance edge.
- tx_valid  in  1  a word is offered.
- tx_last  in  1  sampled together with tx_data; 1 releases CS after this word.
- tx_ready  out  1  the block can accept a word.
- rx_data  out  WORD_BITS  word shifted in from CIPO; held until the next word completes.
- rx_valid  out  1  single-cycle pulse when rx_data updates.
- busy  out  1  high whenever the state is not IDLE.
- SCK  out  1  SPI clock; idles low.
- CS  out  1  chip select, active low; idles high.
- COPI  out  1  serial data out.
- CIPO  in  1  serial data in.

## Operation
- Reset values: SCK=0, CS=1, COPI=0, tx_ready=0 during reset and 1 from the first cycle after reset (IDLE), rx_valid=0, rx_data=0, busy=0.
- Acceptance occurs on an edge where tx_valid && tx_ready. On that edge: load the tx shift register, latch tx_last, set CS=0 and COPI=tx_data[WORD_BITS-1], and enter SHIFT.
- States:
  - IDLE: tx_ready=1, CS=1. Acceptance moves to SHIFT.
  - SHIFT: a half-period counter (0..CLK_DIV-1) toggles SCK on wrap.
    - On each 0→1 toggle, sample CIPO into the rx shift register (LSB in, shift left).
    - On each 1→0 toggle, except the last, drive the next COPI bit.
    - After 2*WORD_BITS toggles: copy the rx shift register to rx_data and pulse rx_valid. Go to HOLD_CS if tx_last=0, else to TRAIL.
  - HOLD_CS: CS stays 0, tx_ready=1, SCK=0. Acceptance goes straight to SHIFT with the new word.
  - TRAIL: CS=0 for CLK_DIV cycles, then CS=1 and enter GAP.
  - GAP: CS=1 for CLK_DIV cycles, then enter IDLE.
- tx_ready is 0 in SHIFT, TRAIL and GAP. tx_valid in those states is ignored and is not queued.
- Counters: half-period counter is $clog2(CLK_DIV+1) bits. Edge counter is $clog2(2*WORD_BITS+1) bits. Both wrap only by explicit reset to 0.
- A reset assertion at any point, including mid-word, forces all outputs to their reset values immediately. The partial rx word is discarded and rx_valid does not pulse.

## Timing
- Edge 0 is the acceptance edge. From edge 0: CS=0 and COPI=MSB.
- SCK rises at edge CLK_DIV, falls at 2*CLK_DIV, and so on. The last fall is at edge 2*WORD_BITS*CLK_DIV (E).
- CIPO is sampled on the CLK edge that sets SCK=1, which is a full half-period after the responder's falling-edge update.
- rx_valid=1 for exactly the cycle after edge E, with rx_data valid from that cycle.
- tx_last=0: tx_ready=1 from edge E. The earliest next acceptance is edge E+1, and its first SCK rise follows CLK_DIV edges later.
- tx_last=1: CS rises at edge E+CLK_DIV. tx_ready returns at edge E+2*CLK_DIV.
- Minimum CS-low to first SCK rise is CLK_DIV cycles. Minimum last SCK fall to CS high is CLK_DIV cycles. Minimum CS high time is CLK_DIV cycles.

## Test plan
- Reset, then idle 10 cycles -> SCK=0, CS=1, COPI=0, tx_ready=1, busy=0, rx_valid never 1.
- WORD_BITS=8, CLK_DIV=2, tx_data=0xA5, tx_last=1, responder model returns 0x3C -> COPI bits 1,0,1,0,0,1,0,1 at the SCK rises.
  - SCK rises at edges 2,6,…,30; last fall at edge 32.
  - rx_data=0x3C with a one-cycle rx_valid after edge 32.
  - CS high at edge 34; tx_ready at edge 36.
- Two words 0x01 (tx_last=0) then 0xFF (tx_last=1), offered back-to-back -> CS stays low across both, second acceptance at edge 33, two rx_valid pulses, CS rises once.
- tx_valid pulsed mid-SHIFT with 0x55 -> ignored: no extra word on COPI, and tx_data changes during SHIFT do not alter the transmitted bits.
- resetn_in asserted at edge 10 of a word -> CS=1, SCK=0 asynchronously, no rx_valid. After release, a new 0x81 transfer completes correctly.
- Default parameters (64-bit, CLK_DIV=4), tx_data=0x0123456789ABCDEF looped back CIPO=COPI -> rx_data=0x0123456789ABCDEF after 512 cycles.
